// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding and command opcodes for the shift sequencer.
package shift_seq_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_e;
    localparam logic OP_EXCHANGE = 1'b0;
    localparam logic OP_ROTATE   = 1'b1;
endpackage

// File: rtl/shift_register_right.sv
// shift_register_right: serial-in/serial-out right-shift register, ser_out is q[0].
module shift_register_right #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (shift_en) q <= {ser_in, q[WIDTH-1:1]};
    assign ser_out = q[0];
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: turns word commands into WIDTH LSB-first shift pulses and returns the outgoing word.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             pause,
    output logic             sr_shift_en,
    output logic             sr_ser_in,
    input  logic             sr_ser_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);
    state_e           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [WIDTH-1:0] tx_q, rx_q;
    logic             op_q;
    logic             last;

    assign last        = bit_cnt_q == CNT_W'(WIDTH - 1);
    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign sr_shift_en = (state_q == SHIFT) && !pause;
    // ROTATE recirculates the outgoing bit so the register ends up unchanged
    assign sr_ser_in   = (state_q == SHIFT) ? ((op_q == OP_ROTATE) ? sr_ser_out : tx_q[0]) : 1'b0;
    assign rsp_valid   = state_q == RESP;
    assign rsp_data    = (state_q == RESP) ? rx_q : '0;
    assign busy        = state_q != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            op_q      <= OP_EXCHANGE;
        end else begin
            case (state_q)
                IDLE:
                    if (cmd_valid) begin
                        tx_q      <= cmd_data;
                        op_q      <= cmd_op;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                SHIFT:
                    if (!pause) begin
                        tx_q      <= tx_q >> 1;
                        rx_q      <= {sr_ser_out, rx_q[WIDTH-1:1]};
                        bit_cnt_q <= last ? '0 : bit_cnt_q + 1'b1;
                        if (last) state_q <= RESP;
                    end
                RESP:
                    if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: sequencer driving a real shift register, checked against a word-level register model.
module tb_shift_seq_ctrl;
    localparam int W = 8;

    logic         clk = 0, rst = 1, sr_rst = 1;
    logic         cmd_valid = 0, cmd_ready, cmd_op = 0, pause = 0;
    logic [W-1:0] cmd_data = '0, rsp_data, q;
    logic         sr_shift_en, sr_ser_in, sr_ser_out, rsp_valid, rsp_ready = 0, busy;

    int n_cmp = 0, n_bad = 0;
    logic [W-1:0] model_q = '0;

    typedef struct {
        logic         op;
        logic [W-1:0] data;
        int           pause_after;
        int           pause_len;
        int           hold;
        logic [W-1:0] exp_rsp;
        logic [W-1:0] exp_q;
    } vec_t;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .pause(pause), .sr_shift_en(sr_shift_en), .sr_ser_in(sr_ser_in),
        .sr_ser_out(sr_ser_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    shift_register_right #(.WIDTH(W)) sreg (
        .clk(clk), .rst(sr_rst), .shift_en(sr_shift_en), .ser_in(sr_ser_in),
        .ser_out(sr_ser_out), .q(q)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves in the same phase.
    task automatic do_cmd(input logic op, input logic [W-1:0] data, input int pause_after,
                          input int pause_len, input int hold, input logic [W-1:0] exp_rsp,
                          input logic [W-1:0] exp_q, input bit rand_pause);
        logic [W-1:0] src;
        int pulses = 0, npause = 0, guard = 0, lat = 1;
        src = (op == shift_seq_pkg::OP_ROTATE) ? model_q : data;
        cmd_valid = 1; cmd_op = op; cmd_data = data; rsp_ready = 0;
        @(negedge clk);
        chk("accept_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_data = W'($urandom);
        while (pulses < W && guard < 200) begin
            pause = rand_pause ? ($urandom_range(0, 3) == 0)
                               : (pulses == pause_after && npause < pause_len);
            if (pause) npause++;
            @(negedge clk);
            chk("shift_busy", busy, 1);
            chk("shift_cmd_ready", cmd_ready, 0);
            chk("shift_rsp_valid", rsp_valid, 0);
            chk("shift_en", sr_shift_en, !pause);
            if (sr_shift_en) begin
                chk("ser_in_bit", sr_ser_in, src[pulses]);
                pulses++;
            end
            @(posedge clk); #1;
            lat++; guard++;
        end
        if (guard >= 200) chk("shift_timeout", pulses, W);
        for (int i = 0; i < hold; i++) begin
            pause = $urandom_range(0, 1);
            cmd_valid = (i == 0); cmd_op = $urandom_range(0, 1); cmd_data = W'($urandom);
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_data", rsp_data, exp_rsp);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_shift_en", sr_shift_en, 0);
            @(posedge clk); #1;
            lat++;
        end
        cmd_valid = 0; rsp_ready = 1; pause = $urandom_range(0, 1);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("rsp_ser_in", sr_ser_in, 0);
        guard = 0;
        do begin
            @(posedge clk); #1;
            rsp_ready = 0; pause = 0; lat++; guard++;
            @(negedge clk);
        end while (!cmd_ready && guard < 40);
        chk("latency", lat, 2 + W + npause + hold);
        chk("idle_busy", busy, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_rsp_data", rsp_data, 0);
        chk("reg_q", q, exp_q);
        model_q = exp_q;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[5];
        logic [W-1:0] part, a5;
        vecs[0] = '{1'b0, 8'hB5, -1, 0, 0, 8'h00, 8'hB5};
        vecs[1] = '{1'b0, 8'h3C, -1, 0, 0, 8'hB5, 8'h3C};
        vecs[2] = '{1'b1, 8'h00, -1, 0, 0, 8'h3C, 8'h3C};
        vecs[3] = '{1'b0, 8'hFF,  3, 4, 0, 8'h3C, 8'hFF};
        vecs[4] = '{1'b1, 8'h5A, -1, 0, 5, 8'hFF, 8'hFF};

        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_shift_en", sr_shift_en, 0);
        chk("rst_ser_in", sr_ser_in, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1; rst = 0; sr_rst = 0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        @(posedge clk); #1;

        foreach (vecs[i])
            do_cmd(vecs[i].op, vecs[i].data, vecs[i].pause_after, vecs[i].pause_len,
                   vecs[i].hold, vecs[i].exp_rsp, vecs[i].exp_q, 0);

        a5 = 8'hA5;
        cmd_valid = 1; cmd_op = 0; cmd_data = a5;
        @(posedge clk); #1;
        cmd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pre_rst_shift_en", sr_shift_en, 1);
            @(posedge clk); #1;
        end
        rst = 1;
        #1;
        chk("midrst_shift_en", sr_shift_en, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        part = (model_q >> 4) | (a5 << 4);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("postrst_ready", cmd_ready, 1);
        chk("postrst_rsp_valid", rsp_valid, 0);
        chk("partial_q", q, part);
        model_q = part;
        @(posedge clk); #1;
        do_cmd(1'b0, 8'h11, -1, 0, 0, part, 8'h11, 0);

        for (int i = 0; i < 20; i++) begin
            logic op;
            logic [W-1:0] d;
            op = 1'($urandom_range(0, 1));
            d = W'($urandom);
            do_cmd(op, d, -1, 0, $urandom_range(0, 3), model_q, op ? model_q : d, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the serial-in/serial-out right-shift register (shift_en, ser_in, ser_out, q). It accepts word-level commands over a valid/ready handshake, then drives exactly WIDTH shift pulses, feeding bits LSB-first. In the same pass it captures the outgoing ser_out stream and returns the previous register contents as a response word. It sits between a word-oriented master and the bit-serial register, so the shift timing no longer lives in the testbench.

Parameters:
WIDTH, 8, shift register length and command/response word width
CNT_W, $clog2(WIDTH), bit counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  1  0=EXCHANGE (shift in cmd_data), 1=ROTATE (recirculate ser_out, contents preserved)
cmd_data  input  WIDTH  word to load (EXCHANGE only)
pause  input  1  stall shifting while high
sr_shift_en  output  1  to shift register shift_en
sr_ser_in  output  1  to shift register ser_in
sr_ser_out  input  1  from shift register ser_out (= q[0], pre-edge value)
rsp_valid  output  1  response word available
rsp_ready  input  1  response consumer ready
rsp_data  output  WIDTH  register contents captured before this command
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, SHIFT, RESP. Reset (async, immediate) -> IDLE, bit_cnt=0, tx_reg=0, rx_reg=0, op_reg=0.
- Reset output values: cmd_ready=0 while rst high, and 1 in IDLE afterwards. sr_shift_en=0, sr_ser_in=0, rsp_valid=0, rsp_data=0, busy=0.
- IDLE: cmd_ready=1. When cmd_valid&&cmd_ready at an edge, latch tx_reg=cmd_data and op_reg=cmd_op, clear bit_cnt, and go to SHIFT.
- SHIFT: cmd_ready=0, busy=1. sr_shift_en = !pause (combinational from state and pause).
- sr_ser_in = tx_reg[0] for EXCHANGE, or sr_ser_out (combinational passthrough) for ROTATE. It is 0 outside SHIFT.
- On each edge with sr_shift_en=1:
  - tx_reg >>= 1
  - rx_reg = {sr_ser_out, rx_reg[WIDTH-1:1]}
  - bit_cnt++
- On the pulse where bit_cnt==WIDTH-1, go to RESP.
- Exactly WIDTH shift pulses per command. With no pause, SHIFT lasts WIDTH cycles, starting the cycle after acceptance.
- pause high: shift_en=0; bit_cnt, tx_reg and rx_reg hold. pause has no effect in IDLE or RESP.
- RESP: rsp_valid=1, rsp_data=rx_reg, held stable until rsp_valid&&rsp_ready. Then go to IDLE. No new command is accepted in RESP (no overlap).
- Command-to-IDLE latency with no pause and rsp_ready=1: 1 (accept) + WIDTH (SHIFT) + 1 (RESP) cycles. The next command can be accepted on the first IDLE cycle.
- Result of EXCHANGE: register q == cmd_data; rsp_data == old q.
- Result of ROTATE: q unchanged; rsp_data == q.
- cmd_valid while busy: ignored, not latched. The master must hold it until cmd_ready.
- Reset mid-SHIFT: shift_en drops immediately and the command is dropped with no response. Register contents are partially shifted; this is the user's concern.
- rsp_ready high while not in RESP: ignored.
- WIDTH must be >= 2; the counter wraps naturally at WIDTH-1 -> 0 on completion.

Decomposition:
- Package shift_seq_pkg holds:
  - state enum {IDLE, SHIFT, RESP}
  - op localparams OP_EXCHANGE=1'b0, OP_ROTATE=1'b1
- No sub-module is needed. The bit counter is inline.
- The bench instantiates shift_seq_ctrl plus shift_register_right (WIDTH=8) as the datapath.

Test Plan:
1. Reset, then EXCHANGE 0xB5 -> 8 consecutive shift_en pulses. ser_in sequence 1,0,1,0,1,1,0,1. q=0xB5; rsp_data=0x00.
2. EXCHANGE 0x3C after (1) -> q=0x3C, rsp_data=0xB5. Total cycles from accept to cmd_ready=1 again: 10 with rsp_ready=1.
3. ROTATE after (2) -> 8 shift pulses, q=0x3C at end, rsp_data=0x3C.
4. EXCHANGE 0xFF with pause=1 for 4 cycles after the 3rd pulse -> shift_en low for exactly those 4 cycles. Still 8 pulses total; q=0xFF, rsp_data=0x3C.
5. rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable; cmd_ready=0; a cmd_valid pulse is ignored. Return to IDLE 1 cycle after rsp_ready rises.
6. Assert rst after the 4th pulse of EXCHANGE 0xA5 -> sr_shift_en, rsp_valid and busy go to 0 the same cycle, with no response. After release, cmd_ready=1 and a new EXCHANGE 0x11 gives q=0x11.
